// File: rtl/ascon_fifo_if.sv
// Handshake bundle between the Ascon word FIFO and its producer/consumer.
// The slave modport is the FIFO side; the master modport is the driving block.
interface ascon_fifo_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
);
    logic              flush_i;
    logic              push_i;
    logic [DATA_W-1:0] data_i;
    logic              full_o;
    logic              pop_i;
    logic [DATA_W-1:0] data_o;
    logic              empty_o;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;
    logic              underflow_o;

    modport slave (
        input  flush_i, push_i, data_i, pop_i,
        output full_o, data_o, empty_o, level_o, overflow_o, underflow_o
    );

    modport master (
        output flush_i, push_i, data_i, pop_i,
        input  full_o, data_o, empty_o, level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ascon_fifo.sv
// First-word fall-through word FIFO with wrap-bit pointers, sticky
// overflow/underflow flags and a synchronous flush.
module ascon_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    ascon_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PTR_W:0]    ptr_diff;
    logic              empty, full, pop_ok, push_ok, wr_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign ptr_diff = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop_ok  = bus.pop_i & ~empty;
    assign push_ok = bus.push_i & (~full | pop_ok);
    assign wr_en   = push_ok & ~bus.flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            ovf_d = ovf_q | (bus.push_i & ~push_ok);
            unf_d = unf_q | (bus.pop_i & ~pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Flush moves only the pointers; stale words stay in the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.data_i;
        end
    end

    assign bus.data_o      = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.level_o     = LVL_W'(ptr_diff);
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_ascon_fifo.sv
// Self-checking bench for ascon_fifo: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_ascon_fifo;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .LVL_W(LW)) bus ();
    ascon_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .LVL_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_q[$];
    bit m_ovf, m_unf;

    typedef struct {
        bit          push, pop, flush;
        logic [63:0] data;
        int          lvl;
        bit          empty, full, ovf, unf, chk_data;
        logic [63:0] exp_data;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input bit p, input bit q, input bit f, input logic [DW-1:0] d);
        bit pop_ok, push_ok;
        if (f) begin
            model_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            pop_ok  = q && (model_q.size() > 0);
            push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
            if (q && !pop_ok) m_unf = 1;
            if (p && !push_ok) m_ovf = 1;
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end
    endtask

    task automatic cycle(input bit p, input bit q, input bit f, input logic [DW-1:0] d);
        bus.push_i  = p;
        bus.pop_i   = q;
        bus.flush_i = f;
        bus.data_i  = d;
        @(posedge clk);
        #1;
        model_step(p, q, f, d);
        bus.push_i  = 0;
        bus.pop_i   = 0;
        bus.flush_i = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"}, 64'(bus.level_o), 64'(model_q.size()));
        check({tag, ".empty"}, 64'(bus.empty_o), 64'(model_q.size() == 0));
        check({tag, ".full"},  64'(bus.full_o),  64'(model_q.size() == DEPTH));
        check({tag, ".ovf"},   64'(bus.overflow_o),  64'(m_ovf));
        check({tag, ".unf"},   64'(bus.underflow_o), 64'(m_unf));
        if (model_q.size() > 0) check({tag, ".data"}, bus.data_o, model_q[0]);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] w;
        bit p, q, f;
        int max_lvl;

        tbl[0]  = '{1,0,0,64'h1111_1111_1111_1111, 1,0,0,0,0,1,64'h1111_1111_1111_1111};
        tbl[1]  = '{1,0,0,64'h2222_2222_2222_2222, 2,0,0,0,0,1,64'h1111_1111_1111_1111};
        tbl[2]  = '{1,0,0,64'h3333_3333_3333_3333, 3,0,0,0,0,1,64'h1111_1111_1111_1111};
        tbl[3]  = '{1,0,0,64'h4444_4444_4444_4444, 4,0,1,0,0,1,64'h1111_1111_1111_1111};
        tbl[4]  = '{1,0,0,64'h5555_5555_5555_5555, 4,0,1,1,0,1,64'h1111_1111_1111_1111};
        tbl[5]  = '{1,1,0,64'hAAAA_AAAA_AAAA_AAAA, 4,0,1,1,0,1,64'h2222_2222_2222_2222};
        tbl[6]  = '{0,1,0,64'h0,                    3,0,0,1,0,1,64'h3333_3333_3333_3333};
        tbl[7]  = '{0,1,0,64'h0,                    2,0,0,1,0,1,64'h4444_4444_4444_4444};
        tbl[8]  = '{0,1,0,64'h0,                    1,0,0,1,0,1,64'hAAAA_AAAA_AAAA_AAAA};
        tbl[9]  = '{0,1,0,64'h0,                    0,1,0,1,0,0,64'h0};
        tbl[10] = '{0,1,0,64'h0,                    0,1,0,1,1,0,64'h0};
        tbl[11] = '{0,0,1,64'h0,                    0,1,0,0,0,0,64'h0};
        tbl[12] = '{1,1,0,64'h7777_7777_7777_7777, 1,0,0,0,1,1,64'h7777_7777_7777_7777};
        tbl[13] = '{1,0,1,64'h8888_8888_8888_8888, 0,1,0,0,0,0,64'h0};

        rst = 1;
        bus.push_i = 0; bus.pop_i = 0; bus.flush_i = 0; bus.data_i = '0;
        @(posedge clk);
        #1;
        check("rst.empty", 64'(bus.empty_o), 64'd1);
        check("rst.full",  64'(bus.full_o),  64'd0);
        check("rst.level", 64'(bus.level_o), 64'd0);
        check("rst.data",  bus.data_o,       64'd0);
        check("rst.ovf",   64'(bus.overflow_o),  64'd0);
        check("rst.unf",   64'(bus.underflow_o), 64'd0);
        rst = 0;
        model_q.delete(); m_ovf = 0; m_unf = 0;
        $display("reset: empty=%0d level=%0d data=%h", bus.empty_o, bus.level_o, bus.data_o);

        // Directed table: fill, overflow, push+pop while full, drain, underflow, flush.
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].data);
            $display("vec %0d: push=%0d pop=%0d flush=%0d level=%0d data=%h ovf=%0d unf=%0d",
                     i, tbl[i].push, tbl[i].pop, tbl[i].flush, bus.level_o, bus.data_o,
                     bus.overflow_o, bus.underflow_o);
            check($sformatf("vec%0d.level", i), 64'(bus.level_o), 64'(tbl[i].lvl));
            check($sformatf("vec%0d.empty", i), 64'(bus.empty_o), 64'(tbl[i].empty));
            check($sformatf("vec%0d.full", i),  64'(bus.full_o),  64'(tbl[i].full));
            check($sformatf("vec%0d.ovf", i),   64'(bus.overflow_o),  64'(tbl[i].ovf));
            check($sformatf("vec%0d.unf", i),   64'(bus.underflow_o), 64'(tbl[i].unf));
            if (tbl[i].chk_data) check($sformatf("vec%0d.data", i), bus.data_o, tbl[i].exp_data);
        end

        // Pop on empty right after reset, then flush clears the flag.
        do_reset();
        cycle(0, 1, 0, '0);
        $display("pop-empty: level=%0d unf=%0d", bus.level_o, bus.underflow_o);
        check("popempty.unf",   64'(bus.underflow_o), 64'd1);
        check("popempty.level", 64'(bus.level_o), 64'd0);
        check("popempty.empty", 64'(bus.empty_o), 64'd1);
        cycle(0, 0, 1, '0);
        $display("flush: unf=%0d", bus.underflow_o);
        check("flush.unf", 64'(bus.underflow_o), 64'd0);
        cycle(1, 0, 0, 64'h0000_0000_00C0_FFEE);
        check("afterpop.data",  bus.data_o, 64'h0000_0000_00C0_FFEE);
        check("afterpop.level", 64'(bus.level_o), 64'd1);
        cycle(0, 1, 0, '0);

        // Alternating push/pop across the pointer wrap.
        max_lvl = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                w = {$urandom, $urandom};
                cycle(1, 0, 0, w);
                check($sformatf("alt%0d.data", i), bus.data_o, w);
            end else begin
                cycle(0, 1, 0, '0);
            end
            if (int'(bus.level_o) > max_lvl) max_lvl = int'(bus.level_o);
            $display("alt %0d: level=%0d data=%h", i, bus.level_o, bus.data_o);
            check($sformatf("alt%0d.level", i), 64'(bus.level_o), 64'((i % 2 == 0) ? 1 : 0));
        end
        check("alt.maxlevel", 64'(max_lvl), 64'd1);

        // Flush with a concurrent push at level 3 drops the push.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 64'(i + 16'h100));
        check("fl3.level", 64'(bus.level_o), 64'd3);
        cycle(1, 0, 1, 64'hDEAD_DEAD_DEAD_DEAD);
        $display("flush+push: level=%0d empty=%0d ovf=%0d unf=%0d",
                 bus.level_o, bus.empty_o, bus.overflow_o, bus.underflow_o);
        check("flpush.level", 64'(bus.level_o), 64'd0);
        check("flpush.empty", 64'(bus.empty_o), 64'd1);
        check("flpush.ovf",   64'(bus.overflow_o),  64'd0);
        check("flpush.unf",   64'(bus.underflow_o), 64'd0);
        cycle(1, 0, 0, 64'h1234_5678_9ABC_DEF0);
        check("flpush.next", bus.data_o, 64'h1234_5678_9ABC_DEF0);
        check("flpush.lvl1", 64'(bus.level_o), 64'd1);

        // Asynchronous reset between edges at level 2, with a push held in flight.
        cycle(1, 0, 0, 64'h5A5A_5A5A_5A5A_5A5A);
        check("arst.pre", 64'(bus.level_o), 64'd2);
        #2;
        rst = 1;
        #1;
        $display("async rst: empty=%0d level=%0d data=%h", bus.empty_o, bus.level_o, bus.data_o);
        check("arst.empty", 64'(bus.empty_o), 64'd1);
        check("arst.data",  bus.data_o, 64'd0);
        check("arst.level", 64'(bus.level_o), 64'd0);
        bus.push_i = 1;
        bus.data_i = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk);
        #1;
        rst = 0;
        bus.push_i = 0;
        model_q.delete(); m_ovf = 0; m_unf = 0;
        check("arst.hold", 64'(bus.empty_o), 64'd1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 31) == 0);
            w = {$urandom, $urandom};
            cycle(p, q, f, w);
            $display("rnd %0d: push=%0d pop=%0d flush=%0d level=%0d", i, p, q, f, bus.level_o);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
